if_id_queue: RTL and testbench

// Parametrised IF->ID instruction buffer replacing the single-entry IF/ID latch.

---
 rtl/if_id_queue_pkg.sv | 7 +
 rtl/if_id_queue.sv | 73 +++++++
 tb/tb_if_id_queue.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/if_id_queue_pkg.sv
// rtl/if_id_queue_pkg.sv - shared width defaults and control constants for the IF->ID queue
package if_id_queue_pkg;
   localparam int DefXlen = 32;
   localparam logic [DefXlen-1:0] ZeroWord = '0;
   localparam logic Enable = 1'b1;
   localparam logic Disable = 1'b0;
endpackage

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - circular FIFO buffering fetched {pc, inst} pairs between IF and ID
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int XLEN   = DefXlen,
   parameter int PC_ADJ = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     if_valid,
   input  logic [XLEN-1:0]          if_pc,
   input  logic [XLEN-1:0]          if_inst,
   output logic                     if_ready,
   output logic                     id_valid,
   output logic [XLEN-1:0]          id_pc,
   output logic [XLEN-1:0]          id_inst,
   input  logic                     id_ready,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [2*XLEN-1:0] mem_q [0:DEPTH-1];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              push, pop;

   // if_ready looks at occupancy only, so a full queue refuses a push even while ID pops.
   assign if_ready = (count_q < CW'(DEPTH)) ? Enable : Disable;
   assign id_valid = (count_q != '0) ? Enable : Disable;
   assign push     = if_valid & if_ready;
   assign pop      = id_valid & id_ready;
   assign count    = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush && push)
         mem_q[wr_ptr_q] <= {if_pc - XLEN'(PC_ADJ), if_inst};
   end

   // Idle bus reads as zero so decode never sees a stale entry.
   assign {id_pc, id_inst} = (id_valid == Enable) ? mem_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - randomized scoreboard bench for if_id_queue
module tb_if_id_queue;
   localparam int DEPTH  = 4;
   localparam int XLEN   = 32;
   localparam int PC_ADJ = 4;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst, flush, if_valid, id_ready;
   logic [XLEN-1:0] if_pc, if_inst;
   logic            if_ready, id_valid;
   logic [XLEN-1:0] id_pc, id_inst;
   logic [CW-1:0]   count;

   if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .PC_ADJ(PC_ADJ)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
      .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_ready(id_ready),
      .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } ent_t;

   ent_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;
   bit   mon_en     = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: an ordered list of accepted entries, bounded at DEPTH.
   always @(posedge clk) begin : model
      int n;
      bit do_pop, do_push;
      n = exp_q.size();
      if (rst || flush) begin
         exp_q.delete();
      end else begin
         do_pop  = id_ready && (n > 0);
         do_push = if_valid && (n < DEPTH);
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) exp_q.push_back('{if_pc - 32'(PC_ADJ), if_inst});
      end
   end

   // Monitor: outputs depend on state only, so sampling on the falling edge is race-free.
   always @(negedge clk) begin : monitor
      int n;
      if (mon_en) begin
         n = exp_q.size();
         chk("count",    64'(count),    64'(n));
         chk("count_le_depth", 64'(count <= CW'(DEPTH)), 64'd1);
         chk("if_ready", 64'(if_ready), 64'(n < DEPTH));
         chk("id_valid", 64'(id_valid), 64'(n != 0));
         chk("id_pc",    64'(id_pc),    (n != 0) ? 64'(exp_q[0].pc)   : 64'd0);
         chk("id_inst",  64'(id_inst),  (n != 0) ? 64'(exp_q[0].inst) : 64'd0);
      end
   end

   task automatic cyc(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst,
                      input logic rdy, input logic fl);
      if_valid = v;
      if_pc    = pc;
      if_inst  = inst;
      id_ready = rdy;
      flush    = fl;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
      if_pc = '0; if_inst = '0;
      @(negedge clk);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      rst = 1'b0;
      mon_en = 1'b1;
      chk("rst_id_valid", 64'(id_valid), 64'd0);
      chk("rst_id_pc",    64'(id_pc),    64'd0);
      chk("rst_id_inst",  64'(id_inst),  64'd0);
      chk("rst_if_ready", 64'(if_ready), 64'd1);
      chk("rst_count",    64'(count),    64'd0);

      for (int i = 0; i < 4; i++) cyc(1, 32'h104 + 32'(4*i), 32'hA0 + 32'(i), 0, 0);
      chk("fill_count",    64'(count),    64'd4);
      chk("fill_if_ready", 64'(if_ready), 64'd0);
      chk("fill_id_pc",    64'(id_pc),    64'h100);
      chk("fill_id_inst",  64'(id_inst),  64'hA0);
      cyc(1, 32'h114, 32'hA4, 0, 0);
      chk("fifth_push_count", 64'(count), 64'd4);

      for (int i = 0; i < 4; i++) begin
         chk("drain_id_pc", 64'(id_pc), 64'h100 + 64'(4*i));
         cyc(0, 0, 0, 1, 0);
      end
      chk("drain_id_valid", 64'(id_valid), 64'd0);
      chk("drain_id_pc",    64'(id_pc),    64'd0);
      chk("drain_count",    64'(count),    64'd0);

      for (int i = 0; i < 10; i++) begin
         cyc(1, 32'h304 + 32'(4*i), 32'hB0 + 32'(i), 1, 0);
         chk("stream_count", 64'(count), 64'd1);
         chk("stream_id_pc", 64'(id_pc), 64'h300 + 64'(4*i));
      end
      cyc(0, 0, 0, 1, 0);

      for (int i = 0; i < 3; i++) cyc(1, 32'h404 + 32'(4*i), 32'hC0 + 32'(i), 0, 0);
      chk("pre_flush_count", 64'(count), 64'd3);
      cyc(1, 32'h500, 32'hCF, 1, 1);
      chk("flush_count",    64'(count),    64'd0);
      chk("flush_id_valid", 64'(id_valid), 64'd0);
      cyc(1, 32'h204, 32'hD0, 0, 0);
      chk("post_flush_id_pc",   64'(id_pc),   64'h200);
      chk("post_flush_id_inst", 64'(id_inst), 64'hD0);

      for (int i = 0; i < 3; i++) cyc(1, 32'h604 + 32'(4*i), 32'hE0 + 32'(i), 0, 0);
      chk("full_count", 64'(count), 64'd4);
      cyc(1, 32'h700, 32'hEF, 1, 0);
      chk("full_pop_count",    64'(count),    64'd3);
      chk("full_pop_if_ready", 64'(if_ready), 64'd1);

      for (int i = 0; i < 500; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         cyc(1'($urandom_range(0, 2) != 0), $urandom, $urandom,
             1'($urandom_range(0, 2) == 0 ? 1 : $urandom_range(0, 1)),
             1'($urandom_range(0, 15) == 0));
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
